// File: rtl/fib_seq_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : fib_seq_gen_if
//  Description : Output stream bundle of the Fibonacci generator. Carries one
//                term per accepted valid/ready beat together with its index
//                and an end-of-sequence marker.
//  Signals     : out_valid  master->slave  term on out_data/out_idx is valid
//                out_ready  slave->master  downstream accepts the term
//                out_data   master->slave  term value, WIDTH bits
//                out_idx    master->slave  term index, IDX_W bits
//                out_last   master->slave  final term of the sequence
//  Revision    : 1.0  initial release
// ============================================================================
interface fib_seq_gen_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fib_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fib_seq_gen
//  Description : Parametrised Fibonacci sequence generator. A start request in
//                IDLE latches the target index n and streams F(0)..F(n) over a
//                valid/ready interface, then pulses done for one cycle.
//                Supports backpressure, synchronous abort and a sticky
//                per-run overflow flag.
//  Parameters  : WIDTH  term width (>=2)
//                IDX_W  index width (>=1)
//  Ports       : clk       system clock, rising edge
//                rst_n     asynchronous active-low reset
//                start     request a new sequence (sampled only in IDLE)
//                n         last index to emit, latched on accepted start
//                abort     cancel a running sequence, no done pulse
//                busy      high while a sequence is running
//                overflow  some emitted term of this run exceeded 2^WIDTH-1
//                done      one-cycle pulse after the final beat is accepted
//                out       stream master (out_valid/ready/data/idx/last)
//  Config      : FIB_SAT_EN  when defined, terms saturate at 2^WIDTH-1 once
//                overflow occurs; otherwise they wrap modulo 2^WIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module fib_seq_gen #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  input  wire logic [IDX_W-1:0] n,
  input  wire logic             abort,
  output logic                  busy,
  output logic                  overflow,
  output logic                  done,
  fib_seq_gen_if.master         out
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] n_lat;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] cur;      // term currently presented, F(idx)
  logic [WIDTH-1:0] nxt;      // precomputed F(idx+1)
  logic             nxt_ovf;  // true value of F(idx+1) exceeds the term range
  logic             valid;
  logic             last;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sum_term;
  logic             sum_ovf;
  logic [IDX_W-1:0] idx_inc;
  logic             fire;
  logic             start_ok;

  // F(idx+2) = F(idx) + F(idx+1), kept one bit wider to expose the carry.
  assign sum     = {1'b0, cur} + {1'b0, nxt};
  // Once any earlier term overflowed, every later true term does as well.
  assign sum_ovf = nxt_ovf | sum[WIDTH];

`ifdef FIB_SAT_EN
  assign sum_term = sum_ovf ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign sum_term = sum[WIDTH-1:0];
`endif

  assign idx_inc  = idx + {{(IDX_W-1){1'b0}}, 1'b1};
  assign fire     = valid & out.out_ready;
  // The done cycle is already IDLE, but a start there must be ignored.
  assign start_ok = (state == S_IDLE) & start & ~done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      n_lat    <= '0;
      idx      <= '0;
      cur      <= '0;
      nxt      <= '0;
      nxt_ovf  <= 1'b0;
      valid    <= 1'b0;
      last     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state    <= S_RUN;
            n_lat    <= n;
            idx      <= '0;
            cur      <= '0;
            nxt      <= {{(WIDTH-1){1'b0}}, 1'b1};
            nxt_ovf  <= 1'b0;
            valid    <= 1'b1;
            last     <= (n == '0);
            overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort wins over a simultaneous transfer; the beat is dropped.
            state <= S_IDLE;
            valid <= 1'b0;
            last  <= 1'b0;
          end else if (fire) begin
            if (last) begin
              state <= S_IDLE;
              valid <= 1'b0;
              last  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx      <= idx_inc;
              cur      <= nxt;
              nxt      <= sum_term;
              nxt_ovf  <= sum_ovf;
              // Flag rises together with the first out-of-range term shown.
              overflow <= overflow | nxt_ovf;
              last     <= (idx_inc == n_lat);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          valid <= 1'b0;
          last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = (state == S_RUN);
  assign out.out_valid = valid;
  assign out.out_data  = cur;
  assign out.out_idx   = idx;
  assign out.out_last  = last;

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_seq_gen
//  Description : Self-checking bench for fib_seq_gen. Terms are predicted from
//                the mathematical Fibonacci sequence in 64-bit arithmetic and
//                then reduced (wrap or saturate) to the DUT term width.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fib_seq_gen;
  localparam int WIDTH = 16;
  localparam int IDX_W = 8;
  localparam logic [63:0] TERM_MAX = (64'd1 << WIDTH) - 64'd1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] n     = '0;
  logic             abort = 1'b0;
  logic             busy;
  logic             overflow;
  logic             done;

  int checks = 0;
  int errors = 0;

  fib_seq_gen_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) sif ();

  fib_seq_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n        (n),
    .abort    (abort),
    .busy     (busy),
    .overflow (overflow),
    .done     (done),
    .out      (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact Fibonacci number; fits 64 bits for every index used here.
  function automatic logic [63:0] fib_true(input int i);
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd1;
    logic [63:0] t;
    for (int k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [63:0] exp_term(input int i);
    logic [63:0] t = fib_true(i);
    if (t > TERM_MAX) begin
`ifdef FIB_SAT_EN
      return TERM_MAX;
`else
      return t & TERM_MAX;
`endif
    end
    return t;
  endfunction

  // The sequence is non-decreasing, so "any term so far overflowed" equals
  // "the current term overflowed".
  function automatic logic [63:0] exp_ovf(input int i);
    return (fib_true(i) > TERM_MAX) ? 64'd1 : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ready always high, 1 ready toggles 1/0, 2 random ready.
  // abort_at / reset_at: index at which to abort / reset (-1 = never).
  // poke: randomly raise start (with random n) while busy.
  // done_poke: raise start during the done cycle.
  task automatic run_seq(input int nv, input int mode, input int abort_at,
                         input int reset_at, input bit poke, input bit done_poke);
    int i = 0;
    bit finished = 1'b0;
    bit r;
    start = 1'b1;
    n     = IDX_W'(nv);
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      sif.out_ready = r;
      chk("valid", 64'(sif.out_valid), 64'd1);
      chk("data",  64'(sif.out_data),  exp_term(i));
      chk("idx",   64'(sif.out_idx),   64'(i));
      chk("last",  64'(sif.out_last),  64'(i == nv));
      chk("ovf",   64'(overflow),      exp_ovf(i));
      chk("busy",  64'(busy),          64'd1);
      chk("done_run", 64'(done),       64'd0);
      if (i == abort_at) begin
        abort = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 64'(sif.out_valid), 64'd0);
        chk("abort_busy",  64'(busy),          64'd0);
        chk("abort_done",  64'(done),          64'd0);
        tick();
        chk("abort_done2", 64'(done),          64'd0);
        chk("abort_busy2", 64'(busy),          64'd0);
        finished = 1'b1;
        break;
      end
      if (i == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data",  64'(sif.out_data),  64'd0);
        chk("arst_idx",   64'(sif.out_idx),   64'd0);
        chk("arst_valid", 64'(sif.out_valid), 64'd0);
        chk("arst_last",  64'(sif.out_last),  64'd0);
        chk("arst_busy",  64'(busy),          64'd0);
        chk("arst_ovf",   64'(overflow),      64'd0);
        chk("arst_done",  64'(done),          64'd0);
        #3 rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy",  64'(busy),          64'd0);
        chk("post_rst_valid", 64'(sif.out_valid), 64'd0);
        finished = 1'b1;
        break;
      end
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        n     = IDX_W'($urandom_range(0, 30));
      end
      tick();
      start = 1'b0;
      if (r) begin
        if (i == nv) begin
          finished = 1'b1;
          break;
        end
        i++;
      end
    end
    chk("timeout", 64'(finished), 64'd1);
    if (abort_at < 0 && reset_at < 0) begin
      chk("end_valid", 64'(sif.out_valid), 64'd0);
      chk("end_busy",  64'(busy),          64'd0);
      chk("end_done",  64'(done),          64'd1);
      if (done_poke) begin
        start = 1'b1;
        n     = 8'd3;
      end
      tick();
      start = 1'b0;
      chk("done_pulse", 64'(done),          64'd0);
      chk("idle_busy",  64'(busy),          64'd0);
      chk("idle_valid", 64'(sif.out_valid), 64'd0);
    end
    sif.out_ready = 1'b0;
    tick();
  endtask

  initial begin
    sif.out_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(sif.out_valid), 64'd0);
    chk("rst_data",  64'(sif.out_data),  64'd0);
    chk("rst_idx",   64'(sif.out_idx),   64'd0);
    chk("rst_last",  64'(sif.out_last),  64'd0);
    chk("rst_busy",  64'(busy),          64'd0);
    chk("rst_ovf",   64'(overflow),      64'd0);
    chk("rst_done",  64'(done),          64'd0);
    rst_n = 1'b1;
    tick();

    // Abort while idle has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy",  64'(busy),          64'd0);
    chk("idle_abort_valid", 64'(sif.out_valid), 64'd0);

    run_seq(10, 0, -1, -1, 1'b0, 1'b0);   // 0..55, one per cycle
    run_seq(5,  1, -1, -1, 1'b0, 1'b0);   // ready toggling
    run_seq(0,  0, -1, -1, 1'b0, 1'b1);   // single beat, start in done cycle
    run_seq(1,  0, -1, -1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_seq(int'($urandom_range(0, 30)), 2, -1, -1, 1'b1, 1'b0);
    run_seq(26, 0, -1, -1, 1'b0, 1'b0);   // crosses 2^16 at F(25)
    run_seq(20, 0, 7, -1, 1'b0, 1'b0);    // abort at index 7
    run_seq(30, 2, 27, -1, 1'b0, 1'b0);   // abort after overflow
    run_seq(3,  0, -1, -1, 1'b0, 1'b0);   // overflow cleared by new start
    run_seq(30, 2, -1, 27, 1'b0, 1'b0);   // async reset mid-run
    run_seq(4,  1, -1, -1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
